axi_read_responder: RTL
=======================

Name: axi_read_responder

Overview:
- Single-port AXI4 read-channel slave (AR + R channels) that serves read bursts from an internal word-addressed memory.
- It is the responder counterpart to the VGA frame fetcher's read initiator.
- Used as an on-chip frame-buffer/BRAM target and as the bench memory for the fetch path.
- Memory is preloaded through a simple write port and has no reset.

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, R data width; power of two, 8..128.
- MEM_AW, 10, log2 of memory depth in DATA_WIDTH words.
- BASE_ADDR, 0, byte address of memory word 0; must be aligned to DATA_WIDTH/8.

Ports:
- clk_a  in  1  clock.
- resetn_a  in  1  reset; asynchronous, active-low.
- araddr_i  in  ADDR_WIDTH  burst start byte address.
- arburst_i  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- arlen_i  in  8  beats minus 1.
- arsize_i  in  3  log2 bytes per beat.
- arvalid_i  in  1  address valid.
- arready_o  out  1  address accepted.
- rdata_o  out  DATA_WIDTH  read data.
- rresp_o  out  2  response: 0 OKAY, 2 SLVERR, 3 DECERR.
- rlast_o  out  1  final beat of burst.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  master ready.
- mem_we_i  in  1  preload write enable.
- mem_waddr_i  in  MEM_AW  preload word index.
- mem_wdata_i  in  DATA_WIDTH  preload data.

Behaviour:
- Reset (async assert, sync release):
  - arready_o=0, rvalid_o=0, rlast_o=0, rresp_o=0, rdata_o=0, state IDLE, beat counter 0.
  - Memory contents are untouched.
  - Reset mid-burst aborts the burst immediately; no further beats are issued.
- FSM has two states, IDLE and BURST.
  - IDLE: arready_o=1 (registered; first high one cycle after reset release).
  - IDLE exit: arvalid_i && arready_o latches addr, burst, len, size; clears the beat counter; enters BURST; arready_o=0 next cycle.
  - BURST: rvalid_o=1 starting the cycle after the AR handshake (1-cycle latency), carrying beat 0.
  - BURST, beat handshake (rvalid_o && rready_i), not last: the next beat is presented the following cycle (zero bubble). Back-to-back 256-beat burst takes 257 cycles from AR handshake to last handshake with rready_i held high.
  - BURST, beat handshake on last beat: rvalid_o=0 and rlast_o=0 next cycle; return to IDLE with arready_o=1 the same cycle.
  - Exactly one burst outstanding: arready_o and rvalid_o are never both 1.
- Stall rule: while rvalid_o && !rready_i, rdata_o, rresp_o and rlast_o hold stable.
- rlast_o=1 exactly on beat arlen_i (the count of beats is arlen+1). arlen=0 gives a single beat with rlast_o=1.
- Beat address:
  - Beat 0 uses araddr_i.
  - INCR: next = (addr & ~((1<<size)-1)) + (1<<size), modulo 2^ADDR_WIDTH.
  - FIXED: address constant for all beats.
  - 4KB boundary is not checked.
- Data:
  - word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to MEM_AW bits.
  - The full word is returned on all lanes; the master selects lanes for narrow sizes.
- Errors (per beat, priority order):
  - arburst=2 or 3, or (1<<arsize) > DATA_WIDTH/8: rresp_o=2 (SLVERR) and rdata_o=0 on every beat. The full arlen+1 beats are still returned with correct rlast_o.
  - Beat address outside [BASE_ADDR, BASE_ADDR + 2^MEM_AW*DATA_WIDTH/8): rresp_o=3 (DECERR), rdata_o=0, for that beat only.
  - Otherwise rresp_o=0 (OKAY).
- Memory timing:
  - Beat data is sampled from the array at the clock edge that loads the beat.
  - A preload write to the same word on that edge is not visible; the old data is returned.
  - Writes are accepted in any state.

Test Plan:
- Preload word i = 64'h1000_0000_0000_0000+i; INCR, araddr=BASE, len=31, size=3, rready=1 -> 32 OKAY beats with data +0..+31, rlast on beat 31 only, arready low from cycle after AR until the cycle after the last beat.
- Same burst with rready toggling 1,0,0,1 pattern -> no beat skipped or duplicated, outputs stable during stalls, 32 beats delivered in order.
- FIXED, araddr=BASE+8, len=3 -> 4 beats all data word 1, OKAY.
- INCR starting 2 words below memory top, len=3 -> beats 0-1 OKAY with data, beats 2-3 DECERR with rdata=0, rlast on beat 3.
- WRAP burst len=1, and a separate INCR burst with size=4 (DATA_WIDTH=64) -> 2 SLVERR beats each, rdata=0, rlast on second beat, FSM back to IDLE.
- Assert resetn_a low mid-burst (beat 10 of 32) -> rvalid_o and rlast_o drop immediately; arready_o=1 one cycle after release; a new burst returns preloaded data intact.

Source files
------------

// File: rtl/axi_read_responder.sv
// AXI4 read-channel slave serving bursts from an internal word-addressed memory.
// One burst is outstanding at a time; the memory is preloaded via a simple write port.
module axi_read_responder #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_a,
    input  logic                  resetn_a,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [1:0]            arburst_i,
    input  logic [7:0]            arlen_i,
    input  logic [2:0]            arsize_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic                  mem_we_i,
    input  logic [MEM_AW-1:0]     mem_waddr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i
);

    localparam int         BYTE_SH  = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0] MAX_SIZE = 3'(BYTE_SH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state_q, state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic                    rlast_q, rlast_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic                    incr_q, incr_d;
    logic                    slverr_q, slverr_d;
    logic [7:0]              cnt_q, cnt_d;

    logic                    load;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic                    beat_err;
    logic                    beat_last;
    logic [ADDR_WIDTH:0]     beat_off;

    logic [DATA_WIDTH-1:0]   mem [0:(1<<MEM_AW)-1];

    // Address of the following beat: INCR aligns then steps by the beat size, others hold.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0]            sz,
                                                        input logic                  inc);
        logic [ADDR_WIDTH-1:0] step;
        step = ADDR_WIDTH'(1) << sz;
        if (inc) return (a & ~(step - ADDR_WIDTH'(1))) + step;
        return a;
    endfunction

    // Preload port; no reset so contents survive a reset of the read logic.
    always_ff @(posedge clk_a) begin
        if (mem_we_i) mem[mem_waddr_i] <= mem_wdata_i;
    end

    // Next-state, handshake and beat loading; a beat is loaded on AR accept or on a non-last R accept.
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        incr_d    = incr_q;
        slverr_d  = slverr_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        beat_addr = next_addr(addr_q, size_q, incr_q);
        beat_err  = slverr_q;
        beat_last = ((cnt_q + 8'd1) == len_q);

        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (arvalid_i && arready_q) begin
                    state_d   = BURST;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    addr_d    = araddr_i;
                    len_d     = arlen_i;
                    size_d    = arsize_i;
                    incr_d    = (arburst_i == 2'd1);
                    slverr_d  = arburst_i[1] || (arsize_i > MAX_SIZE);
                    cnt_d     = 8'd0;
                    beat_addr = araddr_i;
                    beat_err  = slverr_d;
                    beat_last = (arlen_i == 8'd0);
                    load      = 1'b1;
                end
            end
            BURST: begin
                if (rvalid_q && rready_i) begin
                    if (rlast_q) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        addr_d = beat_addr;
                        cnt_d  = cnt_q + 8'd1;
                        load   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Word offset carries a borrow bit so addresses below the base fall out of range.
        beat_off = ({1'b0, beat_addr} - {1'b0, BASE_ADDR}) >> BYTE_SH;
        if (load) begin
            rlast_d = beat_last;
            if (beat_err) begin
                rresp_d = 2'd2;
                rdata_d = '0;
            end else if (beat_off[ADDR_WIDTH:MEM_AW] != '0) begin
                rresp_d = 2'd3;
                rdata_d = '0;
            end else begin
                rresp_d = 2'd0;
                rdata_d = mem[beat_off[MEM_AW-1:0]];
            end
        end
    end

    // State and output registers; reset aborts any burst in progress.
    always_ff @(posedge clk_a or negedge resetn_a) begin
        if (!resetn_a) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'd0;
            rdata_q   <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            incr_q    <= 1'b0;
            slverr_q  <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            incr_q    <= incr_d;
            slverr_q  <= slverr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rlast_o   = rlast_q;
    assign rresp_o   = rresp_q;
    assign rdata_o   = rdata_q;

endmodule
